// File: rtl/pc_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_load_ctrl
// Description : Program-counter load / step / run controller. Debounces the
//               load and step pushbuttons, synchronises the run switch, and
//               sequences single-cycle PC update enables in IDLE, RUN, LOAD
//               and (optionally) HALT states.
//               Optional feature macro: PC_LOAD_CTRL_HALT_ON_EXC_EN
//               (defined: an exception on an issuing advance halts the core).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_load_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RUN_DIV         = 4
) (
    input  logic       SYS_clk,
    input  logic       SYS_rst,
    input  logic       SYS_load,
    input  logic       SYS_step,
    input  logic       SYS_run,
    input  logic [7:0] SYS_pc_val,
    input  logic       EH_flag,
    input  logic [7:0] PC_next_core,
    output logic [7:0] PC_next,
    output logic       PC_en,
    output logic [1:0] CTRL_state,
    output logic       halted
);

    // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int                c_DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST  = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]        c_DIV_LAST = 8'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_LOAD = 2'b10,
        S_HALT = 2'b11
    } state_t;

    state_t     r_state;
    logic       r_pc_en;
    logic       r_halted;
    logic [7:0] r_div;
    logic       r_run_s1;
    logic       r_run_s2;

    // Bit 0 = load button, bit 1 = step button.
    logic [1:0] w_btn_raw;
    logic [1:0] w_btn_p;
    logic       w_load_p;
    logic       w_step_p;
    logic       w_exc;

    assign w_btn_raw = {SYS_step, SYS_load};
    assign w_load_p  = w_btn_p[0];
    assign w_step_p  = w_btn_p[1];

`ifdef PC_LOAD_CTRL_HALT_ON_EXC_EN
    assign w_exc = EH_flag;
`else
    // Exceptions never stop the core in this build.
    logic w_unused_eh;
    assign w_unused_eh = EH_flag;
    assign w_exc       = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic              r_s1;
            logic              r_s2;
            logic              r_db;
            logic              r_db_d;
            logic [c_DB_W-1:0] r_cnt;

            // Synchronise, debounce and delay the button level for edge detection.
            always_ff @(posedge SYS_clk or negedge SYS_rst) begin
                if (!SYS_rst) begin
                    r_s1   <= 1'b0;
                    r_s2   <= 1'b0;
                    r_db   <= 1'b0;
                    r_db_d <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    r_s1   <= w_btn_raw[gi];
                    r_s2   <= r_s1;
                    r_db_d <= r_db;
                    if (r_s2 != r_db) begin
                        if (r_cnt == c_DB_LAST) begin
                            r_db  <= r_s2;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end

            // Press (rising debounced level) only; release makes no pulse.
            assign w_btn_p[gi] = r_db & ~r_db_d;
        end
    endgenerate

    // Two-flop synchroniser for the run/step mode switch.
    always_ff @(posedge SYS_clk or negedge SYS_rst) begin
        if (!SYS_rst) begin
            r_run_s1 <= 1'b0;
            r_run_s2 <= 1'b0;
        end else begin
            r_run_s1 <= SYS_run;
            r_run_s2 <= r_run_s1;
        end
    end

    // Control FSM: load has top priority from every state and suppresses
    // any core advance in the same cycle.
    always_ff @(posedge SYS_clk or negedge SYS_rst) begin
        if (!SYS_rst) begin
            r_state  <= S_IDLE;
            r_pc_en  <= 1'b0;
            r_halted <= 1'b0;
            r_div    <= 8'd0;
        end else begin
            r_pc_en <= 1'b0;
            if (w_load_p) begin
                r_state  <= S_LOAD;
                r_pc_en  <= 1'b1;
                r_halted <= 1'b0;
                r_div    <= 8'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_div <= 8'd0;
                        if (w_step_p && w_exc) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            if (w_step_p) begin
                                r_pc_en <= 1'b1;
                            end
                            if (r_run_s2) begin
                                r_state <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        if (!r_run_s2) begin
                            r_state <= S_IDLE;
                            r_div   <= 8'd0;
                        end else if (r_div == c_DIV_LAST) begin
                            r_div <= 8'd0;
                            if (w_exc) begin
                                r_state  <= S_HALT;
                                r_halted <= 1'b1;
                            end else begin
                                r_pc_en <= 1'b1;
                            end
                        end else begin
                            r_div <= r_div + 1'b1;
                        end
                    end
                    S_LOAD: begin
                        r_div   <= 8'd0;
                        r_state <= r_run_s2 ? S_RUN : S_IDLE;
                    end
                    S_HALT: begin
                        // Only a load releases the halt (handled above).
                        r_halted <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign PC_next    = (r_state == S_LOAD) ? SYS_pc_val : PC_next_core;
    assign PC_en      = r_pc_en;
    assign CTRL_state = r_state;
    assign halted     = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_pc_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_load_ctrl
// Description : Directed self-checking bench for pc_load_ctrl. A second
//               instance with RUN_DIV=1 shares the inputs for the every-cycle
//               run case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_load_ctrl;

    localparam int D = 16;

    logic       SYS_clk;
    logic       SYS_rst;
    logic       SYS_load;
    logic       SYS_step;
    logic       SYS_run;
    logic [7:0] SYS_pc_val;
    logic       EH_flag;
    logic [7:0] PC_next_core;
    wire  [7:0] PC_next;
    wire        PC_en;
    wire  [1:0] CTRL_state;
    wire        halted;
    wire  [7:0] PC_next1;
    wire        PC_en1;
    wire  [1:0] CTRL_state1;
    wire        halted1;

    int         n_cmp;
    int         n_bad;
    int         obs_i;
    int         n_pulse;
    int         n_pulse1;
    int         first_i;
    logic [7:0] pc_at;
    logic [1:0] st_at;
    logic [1:0] st_after;
    logic       after_pending;

    pc_load_ctrl #(.DEBOUNCE_CYCLES(D), .RUN_DIV(4)) u_dut (
        .SYS_clk      (SYS_clk),
        .SYS_rst      (SYS_rst),
        .SYS_load     (SYS_load),
        .SYS_step     (SYS_step),
        .SYS_run      (SYS_run),
        .SYS_pc_val   (SYS_pc_val),
        .EH_flag      (EH_flag),
        .PC_next_core (PC_next_core),
        .PC_next      (PC_next),
        .PC_en        (PC_en),
        .CTRL_state   (CTRL_state),
        .halted       (halted)
    );

    pc_load_ctrl #(.DEBOUNCE_CYCLES(D), .RUN_DIV(1)) u_dut1 (
        .SYS_clk      (SYS_clk),
        .SYS_rst      (SYS_rst),
        .SYS_load     (SYS_load),
        .SYS_step     (SYS_step),
        .SYS_run      (SYS_run),
        .SYS_pc_val   (SYS_pc_val),
        .EH_flag      (EH_flag),
        .PC_next_core (PC_next_core),
        .PC_next      (PC_next1),
        .PC_en        (PC_en1),
        .CTRL_state   (CTRL_state1),
        .halted       (halted1)
    );

    initial SYS_clk = 1'b0;
    always #5 SYS_clk = ~SYS_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic obs_clear();
        obs_i         = 0;
        n_pulse       = 0;
        n_pulse1      = 0;
        first_i       = -1;
        pc_at         = 8'hxx;
        st_at         = 2'bxx;
        st_after      = 2'b11;
        after_pending = 1'b0;
    endtask

    // Sample n cycles at the falling edge, logging PC_en pulses.
    task automatic observe(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge SYS_clk);
            obs_i++;
            if (after_pending) begin
                st_after      = CTRL_state;
                after_pending = 1'b0;
            end
            if (PC_en === 1'b1) begin
                n_pulse++;
                if (n_pulse == 1) begin
                    first_i       = obs_i;
                    pc_at         = PC_next;
                    st_at         = CTRL_state;
                    after_pending = 1'b1;
                end
            end
            if (PC_en1 === 1'b1) n_pulse1++;
        end
    endtask

    task automatic test_reset();
        PC_next_core = 8'h33;
        SYS_rst      = 1'b0;
        obs_clear();
        observe(3);
        n_cmp++; if (PC_en !== 1'b0) begin n_bad++; $display("FAIL reset_pc_en: got %b want 0", PC_en); end
        n_cmp++; if (CTRL_state !== 2'b00) begin n_bad++; $display("FAIL reset_state: got %b want 00", CTRL_state); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_cmp++; if (PC_next !== 8'h33) begin n_bad++; $display("FAIL reset_pc_next: got %h want 33", PC_next); end
        SYS_rst = 1'b1;
        observe(3);
    endtask

    task automatic test_reset_hold();
        SYS_rst  = 1'b0;
        SYS_step = 1'b1;
        obs_clear();
        observe(5);
        n_cmp++; if (n_pulse !== 0) begin n_bad++; $display("FAIL hold_in_reset: got %0d pulses want 0", n_pulse); end
        SYS_rst = 1'b1;
        obs_clear();
        observe(30);
        n_cmp++; if (n_pulse !== 1) begin n_bad++; $display("FAIL hold_release_pulses: got %0d want 1", n_pulse); end
        n_cmp++; if (!(first_i >= D + 2 && first_i <= D + 4)) begin
            n_bad++; $display("FAIL hold_release_latency: got %0d want %0d..%0d", first_i, D + 2, D + 4);
        end
        SYS_step = 1'b0;
        observe(25);
    endtask

    task automatic test_step();
        SYS_run      = 1'b0;
        PC_next_core = 8'h11;
        obs_clear();
        SYS_step = 1'b1;
        observe(40);
        SYS_step = 1'b0;
        observe(25);
        n_cmp++; if (n_pulse !== 1) begin n_bad++; $display("FAIL step_pulses: got %0d want 1", n_pulse); end
        n_cmp++; if (!(first_i >= 1 && first_i <= D + 4)) begin
            n_bad++; $display("FAIL step_latency: got %0d want 1..%0d", first_i, D + 4);
        end
        n_cmp++; if (pc_at !== 8'h11) begin n_bad++; $display("FAIL step_pc_next: got %h want 11", pc_at); end
        n_cmp++; if (st_at !== 2'b00) begin n_bad++; $display("FAIL step_state: got %b want 00", st_at); end
    endtask

    task automatic test_bounce();
        obs_clear();
        for (int t = 0; t < 10; t++) begin
            SYS_step = ~SYS_step;
            observe(3);
        end
        SYS_step = 1'b1;
        observe(40);
        SYS_step = 1'b0;
        observe(25);
        n_cmp++; if (n_pulse !== 1) begin n_bad++; $display("FAIL bounce_pulses: got %0d want 1", n_pulse); end
    endtask

    task automatic test_load();
        SYS_pc_val   = 8'h2A;
        PC_next_core = 8'h44;
        obs_clear();
        SYS_load = 1'b1;
        observe(40);
        SYS_load = 1'b0;
        observe(25);
        n_cmp++; if (n_pulse !== 1) begin n_bad++; $display("FAIL load_pulses: got %0d want 1", n_pulse); end
        n_cmp++; if (st_at !== 2'b10) begin n_bad++; $display("FAIL load_state: got %b want 10", st_at); end
        n_cmp++; if (pc_at !== 8'h2A) begin n_bad++; $display("FAIL load_pc_next: got %h want 2a", pc_at); end
        n_cmp++; if (st_after !== 2'b00) begin n_bad++; $display("FAIL load_after_state: got %b want 00", st_after); end
        n_cmp++; if (PC_next !== 8'h44) begin n_bad++; $display("FAIL load_idle_pc_next: got %h want 44", PC_next); end
    endtask

    task automatic test_run();
        SYS_run = 1'b1;
        observe(6);
        obs_clear();
        observe(40);
        n_cmp++; if (!(n_pulse >= 9 && n_pulse <= 11)) begin n_bad++; $display("FAIL run_div4_pulses: got %0d want 9..11", n_pulse); end
        n_cmp++; if (n_pulse1 !== 40) begin n_bad++; $display("FAIL run_div1_pulses: got %0d want 40", n_pulse1); end
        n_cmp++; if (CTRL_state !== 2'b01) begin n_bad++; $display("FAIL run_state: got %b want 01", CTRL_state); end
        SYS_run = 1'b0;
        observe(4);
        n_cmp++; if (CTRL_state !== 2'b00) begin n_bad++; $display("FAIL run_stop_state: got %b want 00", CTRL_state); end
        obs_clear();
        observe(20);
        n_cmp++; if (n_pulse !== 0) begin n_bad++; $display("FAIL run_stop_pulses: got %0d want 0", n_pulse); end
        n_cmp++; if (n_pulse1 !== 0) begin n_bad++; $display("FAIL run_stop_pulses_div1: got %0d want 0", n_pulse1); end
    endtask

    task automatic test_exception();
        SYS_run = 1'b1;
        observe(8);
        EH_flag = 1'b1;
        obs_clear();
        observe(20);
`ifdef PC_LOAD_CTRL_HALT_ON_EXC_EN
        n_cmp++; if (n_pulse !== 0) begin n_bad++; $display("FAIL exc_pulses: got %0d want 0", n_pulse); end
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL exc_halted: got %b want 1", halted); end
        n_cmp++; if (CTRL_state !== 2'b11) begin n_bad++; $display("FAIL exc_state: got %b want 11", CTRL_state); end
        obs_clear();
        SYS_step = 1'b1;
        observe(40);
        SYS_step = 1'b0;
        observe(25);
        n_cmp++; if (n_pulse !== 0) begin n_bad++; $display("FAIL exc_step_pulses: got %0d want 0", n_pulse); end
        n_cmp++; if (CTRL_state !== 2'b11) begin n_bad++; $display("FAIL exc_step_state: got %b want 11", CTRL_state); end
`else
        n_cmp++; if (!(n_pulse >= 4 && n_pulse <= 6)) begin n_bad++; $display("FAIL noexc_pulses: got %0d want 4..6", n_pulse); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL noexc_halted: got %b want 0", halted); end
        n_cmp++; if (CTRL_state !== 2'b01) begin n_bad++; $display("FAIL noexc_state: got %b want 01", CTRL_state); end
`endif
        SYS_run      = 1'b0;
        SYS_pc_val   = 8'h00;
        PC_next_core = 8'h99;
        observe(4);
        obs_clear();
        SYS_load = 1'b1;
        observe(40);
        SYS_load = 1'b0;
        observe(25);
        n_cmp++; if (n_pulse !== 1) begin n_bad++; $display("FAIL exc_load_pulses: got %0d want 1", n_pulse); end
        n_cmp++; if (pc_at !== 8'h00) begin n_bad++; $display("FAIL exc_load_pc_next: got %h want 00", pc_at); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL exc_load_halted: got %b want 0", halted); end
        n_cmp++; if (CTRL_state !== 2'b00) begin n_bad++; $display("FAIL exc_load_state: got %b want 00", CTRL_state); end
        EH_flag = 1'b0;
        observe(2);
    endtask

    task automatic test_simultaneous();
        SYS_run      = 1'b0;
        SYS_pc_val   = 8'h5C;
        PC_next_core = 8'h77;
        obs_clear();
        SYS_load = 1'b1;
        SYS_step = 1'b1;
        observe(40);
        SYS_load = 1'b0;
        SYS_step = 1'b0;
        observe(25);
        n_cmp++; if (n_pulse !== 1) begin n_bad++; $display("FAIL simul_pulses: got %0d want 1", n_pulse); end
        n_cmp++; if (st_at !== 2'b10) begin n_bad++; $display("FAIL simul_state: got %b want 10", st_at); end
        n_cmp++; if (pc_at !== 8'h5C) begin n_bad++; $display("FAIL simul_pc_next: got %h want 5c", pc_at); end
        n_cmp++; if (st_after !== 2'b00) begin n_bad++; $display("FAIL simul_after_state: got %b want 00", st_after); end
    endtask

    task automatic test_reset_abort();
        bit found;
        found      = 1'b0;
        SYS_pc_val = 8'h3C;
        SYS_load   = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge SYS_clk);
            if (CTRL_state === 2'b10) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL abort_reach_load: got %b want 1", found); end
        SYS_rst = 1'b0;
        #1;
        n_cmp++; if (PC_en !== 1'b0) begin n_bad++; $display("FAIL abort_pc_en: got %b want 0", PC_en); end
        n_cmp++; if (CTRL_state !== 2'b00) begin n_bad++; $display("FAIL abort_state: got %b want 00", CTRL_state); end
        SYS_load = 1'b0;
        observe(3);
        SYS_rst = 1'b1;
        obs_clear();
        observe(30);
        n_cmp++; if (n_pulse !== 0) begin n_bad++; $display("FAIL abort_after_pulses: got %0d want 0", n_pulse); end
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        SYS_rst      = 1'b0;
        SYS_load     = 1'b0;
        SYS_step     = 1'b0;
        SYS_run      = 1'b0;
        SYS_pc_val   = 8'h00;
        EH_flag      = 1'b0;
        PC_next_core = 8'h00;
        obs_clear();

        test_reset();
        test_reset_hold();
        test_step();
        test_bounce();
        test_load();
        test_run();
        test_exception();
        test_simultaneous();
        test_reset_abort();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_load_ctrl.md
PC_LOAD_CTRL -- requirements
Module: pc_load_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a new button level (board build uses 500000).
REQ-002 Parameter RUN_DIV, default 4: SYS_clk cycles per PC advance in run mode; legal range 1..255.
REQ-003 SYS_clk  input  1  sole clock; all state on rising edge.
REQ-004 SYS_rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SYS_load  input  1  raw load pushbutton, active-high, asynchronous to SYS_clk.
REQ-006 SYS_step  input  1  raw single-step pushbutton, active-high, asynchronous.
REQ-007 SYS_run  input  1  level switch: 1 = free-run, 0 = single-step; 2-flop synchronised, not debounced.
REQ-008 SYS_pc_val  input  8  PC value to load from switches.
REQ-009 EH_flag  input  1  exception flag from the exception handler for the current instruction.
REQ-010 PC_next_core  input  8  datapath-computed next PC (jump/branch/PC+1 mux output).
REQ-011 PC_next  output  8  next-PC value presented to the PC register.
REQ-012 PC_en  output  1  one-cycle PC update enable; PC register loads PC_next only when high.
REQ-013 CTRL_state  output  2  00 IDLE, 01 RUN, 10 LOAD, 11 HALT.
REQ-014 halted  output  1  high while in HALT.

Function
REQ-015 Each button SHALL pass a 2-flop synchroniser followed by a debounce counter; the debounced level SHALL change only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles; the counter SHALL clear on any cycle where they match.
REQ-016 A rising edge of a debounced level SHALL produce a one-cycle internal pulse (load_p, step_p); release SHALL produce no pulse.
REQ-017 PC_next SHALL equal SYS_pc_val in LOAD, else PC_next_core (combinational).
REQ-018 PC_en SHALL be registered and high for exactly one cycle per advance; never high in HALT or IDLE without step_p.
REQ-019 IDLE: step_p -> PC_en high next cycle; SYS_run=1 -> RUN; load_p -> LOAD.
REQ-020 RUN: divider counts 0..RUN_DIV-1, PC_en high the cycle after count reaches RUN_DIV-1, then wraps to 0; SYS_run=0 -> IDLE with divider cleared; load_p -> LOAD; step_p ignored.
REQ-021 LOAD: held exactly one cycle with PC_en=1; next state RUN if SYS_run=1, else IDLE; divider cleared.
REQ-022 load_p SHALL take effect from every state, including HALT, and SHALL win over simultaneous step_p or divider terminal count (no core advance that cycle).
REQ-023 Exception halt (see Configuration): when an advance would issue and EH_flag=1, PC_en SHALL stay low and state -> HALT; PC remains at the faulting instruction.
REQ-024 HALT exits only via load_p; SYS_run and step_p ignored.
REQ-025 RUN_DIV=1 SHALL give PC_en high every cycle in RUN.

Reset
REQ-026 While SYS_rst=0: state IDLE, PC_en=0, halted=0, CTRL_state=00, divider and debounce counters 0, debounced levels and synchronisers 0.
REQ-027 Reset assertion mid-debounce or mid-LOAD SHALL abort it with no PC_en pulse; a button held through reset release SHALL produce a pulse only after a full DEBOUNCE_CYCLES interval.

Configuration
REQ-028 Macro PC_LOAD_CTRL_HALT_ON_EXC_EN defined: REQ-023 active, HALT reachable.
REQ-029 Macro undefined: EH_flag ignored, HALT unreachable, halted tied 0, advances issue regardless of exceptions.

Verification
REQ-030 Reset, SYS_run=0, SYS_step pulsed high 40 cycles -> exactly one PC_en pulse within DEBOUNCE_CYCLES+4 cycles of press, PC_next=PC_next_core.
REQ-031 SYS_step bouncing (toggle every 3 cycles for 30 cycles, then high 40) -> exactly one PC_en pulse.
REQ-032 SYS_pc_val=8'h2A, press SYS_load -> CTRL_state=10 for one cycle, PC_en=1, PC_next=8'h2A; then IDLE.
REQ-033 SYS_run=1, RUN_DIV=4, 40 cycles -> PC_en pulses every 4th cycle (10 pulses, +/-1); SYS_run->0 -> pulses stop, state IDLE.
REQ-034 Macro defined, RUN, EH_flag=1 -> no further PC_en, halted=1, CTRL_state=11; step ignored; load with 8'h00 -> PC_next=0, halted=0. Macro undefined: same stimulus -> pulses continue.
REQ-035 load and step rising in same cycle -> LOAD taken, PC_next=SYS_pc_val, no extra core advance.
